// File: rtl/mem_controller.sv
// Single-bank memory controller: pops requests from a standard FIFO,
// executes them on a local word array and pushes one response each.
module mem_controller #(
    parameter int MODULE_NUM   = 0,
    parameter int MODULE_WIDTH = 1,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 31,
    parameter int TID_WIDTH    = 16,
    parameter int DEPTH        = 256,
    localparam int REQ_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH,
    localparam int DP_DATA_WIDTH  = TID_WIDTH + REQ_WIDTH,
    localparam int VPI_DATA_WIDTH = TID_WIDTH + DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      read_ctr,
    input  logic [DP_DATA_WIDTH-1:0]  incoming_data,
    input  logic                      empty_signal,
    output logic                      write_ctr,
    output logic [VPI_DATA_WIDTH-1:0] outgoing_data,
    input  logic                      full_signal
);

    localparam int SHIFT = $clog2(MODULE_WIDTH);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        EXEC,
        SEND,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic                      read_ctr_q, read_ctr_d;
    logic                      write_ctr_q, write_ctr_d;
    logic [VPI_DATA_WIDTH-1:0] out_q, out_d;
    logic [VPI_DATA_WIDTH-1:0] resp_q, resp_d;
    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic                      mem_we;

    logic [TID_WIDTH-1:0]      req_tid;
    logic                      req_wr;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_data;
    logic [IDX_W-1:0]          mem_idx;
    logic                      unused_ok;

    assign req_tid  = incoming_data[DP_DATA_WIDTH-1 -: TID_WIDTH];
    assign req_wr   = incoming_data[REQ_WIDTH-1];
    assign req_addr = incoming_data[DATA_WIDTH +: ADDR_WIDTH];
    assign req_data = incoming_data[DATA_WIDTH-1:0];

    // Bank-select bits are dropped; upper bits wrap modulo DEPTH.
    assign mem_idx   = req_addr[SHIFT +: IDX_W];
    assign unused_ok = ^{req_addr, MODULE_NUM[0]};

    assign read_ctr      = read_ctr_q;
    assign write_ctr     = write_ctr_q;
    assign outgoing_data = out_q;

    // Next-state and registered-output decode for the request sequencer.
    always_comb begin
        state_d     = state_q;
        read_ctr_d  = 1'b0;
        write_ctr_d = 1'b0;
        out_d       = out_q;
        resp_d      = resp_q;
        mem_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty_signal) begin
                    read_ctr_d = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                state_d = EXEC;
            end
            EXEC: begin
                mem_we  = req_wr;
                resp_d  = {req_tid, req_wr ? req_data : mem_q[mem_idx]};
                state_d = SEND;
            end
            SEND: begin
                if (!full_signal) begin
                    out_d       = resp_q;
                    write_ctr_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            read_ctr_q  <= 1'b0;
            write_ctr_q <= 1'b0;
            out_q       <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            read_ctr_q  <= read_ctr_d;
            write_ctr_q <= write_ctr_d;
            out_q       <= out_d;
            resp_q      <= resp_d;
        end
    end

    // Local word array, wiped on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= req_data;
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: FIFO models, memory reference model and
// a per-cycle compare against one- and two-bank instances.
module tb_mem_controller;

    localparam int DEPTH = 256;

    typedef struct {
        logic [15:0] tid;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [79:0] incoming_data;
    logic        empty_signal;
    logic        full_signal = 1'b0;
    logic        rd1, wr1, rd2, wr2;
    logic [47:0] out1, out2;

    int          checks = 0;
    int          errors = 0;
    int          nresp = 0;
    bit          hold_empty = 1'b1;
    bit          outst = 1'b0;
    logic [79:0] reqq [$];
    exp_t        expq [$];
    logic [47:0] log1 [$];
    logic [47:0] log2 [$];
    logic [31:0] m1 [DEPTH];
    logic [31:0] m2 [DEPTH];

    always #5 clk = ~clk;

    mem_controller #(.MODULE_WIDTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .read_ctr(rd1), .incoming_data(incoming_data),
        .empty_signal(empty_signal), .write_ctr(wr1),
        .outgoing_data(out1), .full_signal(full_signal)
    );

    mem_controller #(.MODULE_NUM(1), .MODULE_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .read_ctr(rd2), .incoming_data(incoming_data),
        .empty_signal(empty_signal), .write_ctr(wr2),
        .outgoing_data(out2), .full_signal(full_signal)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [79:0] r);
        exp_t        e;
        longint      a;
        int          i1, i2;
        e.tid = r[79:64];
        a     = longint'(r[62:32]);
        i1    = int'(a % DEPTH);
        i2    = int'((a / 2) % DEPTH);
        if (r[63]) begin
            m1[i1] = r[31:0];
            m2[i2] = r[31:0];
        end
        e.d1 = m1[i1];
        e.d2 = m2[i2];
        expq.push_back(e);
    endfunction

    task automatic push(input int tid, input bit w,
                        input logic [30:0] a, input logic [31:0] d);
        reqq.push_back({16'(tid), w, a, d});
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((reqq.size() != 0 || expq.size() != 0 || outst)
               && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     reqq.size() + expq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rd(input int limit);
        int n = 0;
        while (!rd1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rd1) begin
            errors++;
            $display("FAIL wait_rd_timeout: got 0 expected 1");
        end
    endtask

    initial begin : drv
        logic [79:0] r;
        incoming_data = '0;
        empty_signal  = 1'b1;
        forever begin
            @(negedge clk);
            if (rd1) begin
                if (reqq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty: got pop expected none");
                    r = '0;
                end else begin
                    r = reqq.pop_front();
                    model(r);
                end
                incoming_data = {$urandom, $urandom, $urandom};
                empty_signal  = hold_empty || reqq.size() == 0;
                @(posedge clk);
                #1 incoming_data = r;
            end else begin
                empty_signal = hold_empty || reqq.size() == 0;
            end
        end
    end

    initial begin : cmp
        int          cyc = 0;
        int          rd_cyc = 0;
        int          stall = 0;
        logic [47:0] last1 = '0;
        logic [47:0] last2 = '0;
        exp_t        e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                chk("rst_rd", rd1, 0);
                chk("rst_wr", wr1, 0);
                chk("rst_out1", out1, 0);
                chk("rst_out2", out2, 0);
                expq.delete();
                for (int i = 0; i < DEPTH; i++) begin
                    m1[i] = '0;
                    m2[i] = '0;
                end
                outst = 1'b0;
                last1 = '0;
                last2 = '0;
            end else begin
                chk("rd_wr_excl", rd1 && wr1, 0);
                chk("ctl_match", {rd2, wr2}, {rd1, wr1});
                if (rd1) begin
                    chk("rd_while_empty", empty_signal, 0);
                    chk("rd_while_busy", outst, 0);
                    outst  = 1'b1;
                    rd_cyc = cyc;
                    stall  = 0;
                end else if (outst && !wr1 && cyc - rd_cyc >= 3
                             && full_signal) begin
                    stall++;
                end
                if (wr1) begin
                    chk("wr_unexpected", outst, 1);
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_extra: got %0h expected none",
                                 out1);
                    end else begin
                        e = expq.pop_front();
                        chk("resp1", out1, {e.tid, e.d1});
                        chk("resp2", out2, {e.tid, e.d2});
                        chk("latency", cyc - rd_cyc, 3 + stall);
                        last1 = {e.tid, e.d1};
                        last2 = {e.tid, e.d2};
                    end
                    outst = 1'b0;
                    log1.push_back(out1);
                    log2.push_back(out2);
                    nresp++;
                end else begin
                    chk("hold1", out1, last1);
                    chk("hold2", out2, last2);
                end
            end
        end
    end

    initial begin : main
        int n0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_resp_cnt", nresp, 0);
        chk("idle_out", out1, 0);

        hold_empty = 1'b0;
        push(1, 1, 31'd5, 32'd15);
        push(2, 0, 31'd5, 32'd0);
        drain(100);
        chk("lit_wr", log1[0], 48'h0001_0000000F);
        chk("lit_rd", log1[1], 48'h0002_0000000F);
        chk("lit_cnt", nresp, 2);

        push(3, 0, 31'd200, 32'hDEAD);
        drain(100);
        chk("lit_fresh", log1[$], 48'h0003_00000000);

        full_signal = 1'b1;
        push(4, 0, 31'd5, 32'd0);
        wait_rd(50);
        push(5, 0, 31'd200, 32'd0);
        repeat (12) @(negedge clk);
        chk("stall_cnt", nresp, 3);
        full_signal = 1'b0;
        drain(100);
        chk("lit_stall", log1[3], 48'h0004_0000000F);
        chk("stall_after", nresp, 5);

        for (int i = 1; i <= 20; i++) begin
            push(i, 1'($urandom_range(0, 1)),
                 31'($urandom_range(0, 255)), $urandom);
        end
        drain(400);
        chk("stream_cnt", nresp, 25);

        push(40, 1, 31'h4000_0105, 32'h0000ABCD);
        push(41, 0, 31'd5, 32'd0);
        drain(100);
        chk("lit_wrap", log1[$], 48'h0029_0000ABCD);

        push(30, 1, 31'd4, 32'h44);
        push(31, 1, 31'd5, 32'h55);
        push(32, 0, 31'd4, 32'd0);
        push(33, 0, 31'd5, 32'd0);
        drain(100);
        chk("lit_mw2_a", log2[$-1], 48'h0020_00000055);
        chk("lit_mw2_b", log2[$], 48'h0021_00000055);
        chk("lit_mw1_a", log1[$-1], 48'h0020_00000044);

        push(6, 1, 31'd9, 32'h99);
        drain(100);
        full_signal = 1'b1;
        push(7, 1, 31'd9, 32'h77);
        wait_rd(50);
        repeat (4) @(negedge clk);
        n0 = nresp;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        full_signal = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_drop", nresp, n0);
        push(8, 0, 31'd9, 32'd0);
        drain(100);
        chk("rst_cnt", nresp, n0 + 1);
        chk("lit_rst_mem", log1[$], 48'h0008_00000000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- One memory-bank controller. Instances are replicated per channel by the top-level `interface` wrapper.
- Pops requests from an upstream request FIFO. Each request is {TID, rw_flag, address, data}.
- Executes each request against a local word-addressed memory array.
- Pushes one response {TID, data} per request into a downstream response FIFO.

Parameters:
- MODULE_NUM, 0, index of this bank (0..MODULE_WIDTH-1).
- MODULE_WIDTH, 1, total number of banks. Must be a power of two.
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 31, request address width.
- TID_WIDTH, 16, transaction ID width.
- DEPTH, 256, local memory words. Must be a power of two.
- Derived: REQ_WIDTH = 1+ADDR_WIDTH+DATA_WIDTH (64).
- Derived: DP_DATA_WIDTH = TID_WIDTH+REQ_WIDTH (80).
- Derived: VPI_DATA_WIDTH = TID_WIDTH+DATA_WIDTH (48).

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- reset, in, 1: synchronous, active-low reset (sampled on rising clk; 0 = reset).
- read_ctr, out, 1: request FIFO pop (rd_en); one-cycle pulse.
- incoming_data, in, DP_DATA_WIDTH: FIFO head, with these fields:
  - [79:64] TID
  - [63] rw_flag (1=write, 0=read)
  - [62:32] address
  - [31:0] data
- empty_signal, in, 1: request FIFO empty.
- write_ctr, out, 1: response FIFO push (wr_en); one-cycle pulse.
- outgoing_data, out, VPI_DATA_WIDTH: response, [47:32] TID and [31:0] data.
- full_signal, in, 1: response FIFO full.

Behaviour:
- Outputs: all registered.
- Reset (reset==0 at a rising edge):
  - read_ctr=0, write_ctr=0, outgoing_data=0, FSM=IDLE.
  - All DEPTH memory words cleared to 0.
  - Any in-flight request is dropped and no response is produced.
  - Reset overrides all other activity in that cycle.
- Request FIFO contract: standard (non-FWFT). incoming_data is valid in the cycle after the cycle in which read_ctr was high.
- FSM states: IDLE, WAIT, EXEC, SEND, DONE.
- IDLE:
  - If empty_signal==0: read_ctr<=1, go to WAIT.
  - Otherwise stay in IDLE with read_ctr=0.
- WAIT:
  - read_ctr is high during this cycle.
  - read_ctr<=0, go to EXEC.
- EXEC:
  - Capture incoming_data and compute idx = (address >> log2(MODULE_WIDTH)) mod DEPTH.
  - If rw_flag=1: mem[idx]<=data; response data = written data (write acknowledge).
  - If rw_flag=0: response data = mem[idx] before this cycle.
  - Load response register with {TID, response data}, go to SEND.
- SEND:
  - If full_signal==0: outgoing_data<=response, write_ctr<=1, go to DONE.
  - If full_signal==1: hold in SEND, write_ctr=0, outgoing_data unchanged. No request is popped while holding.
- DONE:
  - write_ctr is high during this cycle.
  - write_ctr<=0, go to IDLE.
- Timing:
  - Throughput: one request per 5 cycles when unstalled.
  - Latency: 4 edges from the IDLE cycle in which !empty is seen to the write_ctr-high cycle.
- outgoing_data holds its last value between pushes.
- read_ctr and write_ctr are never high in the same cycle.
- read_ctr is never high while empty_signal was 1 in the deciding IDLE cycle.
- Address handling:
  - Address bits above the index are ignored (wrap-around modulo DEPTH*MODULE_WIDTH).
  - Requests whose low bits differ from MODULE_NUM are still serviced; routing is the upstream's job.
- Ordering: responses emitted in request order. TID is copied unchanged.
- Back-to-back same-address write then read: the read returns the new data.

Test Plan:
- Reset, then hold empty_signal=1 for 20 cycles -> read_ctr, write_ctr stay 0; outgoing_data=0.
- Write TID=1, addr=5, data=15, then read TID=2, addr=5 -> responses {1,15} then {2,15}. Exactly one write_ctr pulse per request; 4-edge latency.
- Read TID=3 from never-written addr=200 after reset -> response {3,0}.
- Hold full_signal=1 for 10 cycles during SEND -> write_ctr stays 0 and no read_ctr pulse. After release, write_ctr pulses once with the correct response.
- empty_signal=0 continuously with TIDs 1..20 and random rw/address 0..255, checked against a reference model -> responses in TID order. Write data echoed; reads return the last written value or 0.
- Assert reset=0 during SEND of TID=7 -> no response for TID=7; outputs 0 next cycle. Memory is cleared: a subsequent read of a previously written address returns 0.
- MODULE_WIDTH=2: writes to addr 4 and 5 -> both map to idx 2, so a read of either returns the latest write.
